// File: rtl/osiris_wb_pkg.sv
// Shared types and constants for the osiris Wishbone arbiter slice.
// Optional watchdog is enabled with the OSIRIS_WB_TIMEOUT_EN macro.
package osiris_wb_pkg;

    localparam int WB_AW_DEFAULT = 32;
    localparam int WB_DW_DEFAULT = 32;

    // Read data returned to a master whose transfer was killed by the watchdog.
    localparam logic [31:0] WB_TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } wb_state_e;

endpackage

// File: rtl/osiris_wb_timeout.sv
// Stall counter for the arbiter watchdog; expire_o is high for the single
// cycle in which the count equals TIMEOUT_CYCLES (used under OSIRIS_WB_TIMEOUT_EN).
module osiris_wb_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] count;

    assign expire_o = (count == LIMIT);

    // Firing clears the count so the next cycle starts a fresh stall window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'd0;
        end else if (clr_i || expire_o) begin
            count <= 8'd0;
        end else if (stall_i) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/osiris_wb_arbiter.sv
// Two-master round-robin Wishbone classic arbiter; grant held for the whole cycle.
// Define OSIRIS_WB_TIMEOUT_EN to add the stall watchdog (osiris_wb_timeout).
module osiris_wb_arbiter
    import osiris_wb_pkg::*;
#(
    parameter int          AW             = WB_AW_DEFAULT,
    parameter int          DW             = WB_DW_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,

    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic            m0_ack_o,
    output logic [DW-1:0]   m0_dat_o,

    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic            m1_ack_o,
    output logic [DW-1:0]   m1_dat_o,

    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    input  logic            s_ack_i,
    input  logic [DW-1:0]   s_dat_i,

    output logic [1:0]      gnt_o,
    output logic            timeout_o
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("osiris_wb_arbiter: TIMEOUT_CYCLES must be 1..255");
    end

    wb_state_e     state;
    logic          last_gnt;   // 0 = M0 owned the bus last, 1 = M1
    logic [1:0]    gnt;

    logic          g_stb;
    logic          expire;
    logic          ack_fwd;
    logic [DW-1:0] dat_fwd;

    // Grant FSM: state, round-robin pointer and registered one-hot grant.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            gnt      <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_cyc_i && (!m1_cyc_i || last_gnt)) begin
                        state    <= G0;
                        last_gnt <= 1'b0;
                        gnt      <= 2'b01;
                    end else if (m1_cyc_i) begin
                        state    <= G1;
                        last_gnt <= 1'b1;
                        gnt      <= 2'b10;
                    end
                end
                G0: begin
                    if (!m0_cyc_i) begin
                        state <= IDLE;
                        gnt   <= 2'b00;
                    end
                end
                G1: begin
                    if (!m1_cyc_i) begin
                        state <= IDLE;
                        gnt   <= 2'b00;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 2'b00;
                end
            endcase
        end
    end

    assign gnt_o = gnt;

    // Slave-side mux; everything is zero while no master owns the bus.
    always_comb begin
        s_cyc_o = 1'b0;
        g_stb   = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        case (state)
            G0: begin
                s_cyc_o = m0_cyc_i;
                g_stb   = m0_stb_i;
                s_we_o  = m0_we_i;
                s_sel_o = m0_sel_i;
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
            end
            G1: begin
                s_cyc_o = m1_cyc_i;
                g_stb   = m1_stb_i;
                s_we_o  = m1_we_i;
                s_sel_o = m1_sel_i;
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
            end
            default: ;
        endcase
    end

    // A watchdog expiry suppresses the strobe and fakes an ack to the owner.
    assign s_stb_o = g_stb & ~expire;
    assign ack_fwd = expire | (s_ack_i & s_stb_o);
    assign dat_fwd = expire ? DW'(WB_TIMEOUT_DATA) : s_dat_i;

    assign m0_ack_o = (state == G0) & ack_fwd;
    assign m1_ack_o = (state == G1) & ack_fwd;
    assign m0_dat_o = (state == G0) ? dat_fwd : '0;
    assign m1_dat_o = (state == G1) ? dat_fwd : '0;

`ifdef OSIRIS_WB_TIMEOUT_EN
    logic stall;
    logic clr;

    assign stall = g_stb & ~s_ack_i;
    assign clr   = (state == IDLE) | (g_stb & s_ack_i);

    osiris_wb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .stall_i  (stall),
        .clr_i    (clr),
        .expire_o (expire)
    );

    assign timeout_o = expire;
`else
    assign expire    = 1'b0;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_osiris_wb_arbiter.sv
// Directed self-checking bench for osiris_wb_arbiter (watchdog checks follow
// OSIRIS_WB_TIMEOUT_EN, with TIMEOUT_CYCLES = 4).
module tb_osiris_wb_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;

    logic            m0_cyc, m0_stb, m0_we;
    logic [DW/8-1:0] m0_sel;
    logic [AW-1:0]   m0_adr;
    logic [DW-1:0]   m0_wdat;
    logic            m0_ack;
    logic [DW-1:0]   m0_rdat;

    logic            m1_cyc, m1_stb, m1_we;
    logic [DW/8-1:0] m1_sel;
    logic [AW-1:0]   m1_adr;
    logic [DW-1:0]   m1_wdat;
    logic            m1_ack;
    logic [DW-1:0]   m1_rdat;

    logic            s_cyc, s_stb, s_we;
    logic [DW/8-1:0] s_sel;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_wdat;
    logic            s_ack;
    logic [DW-1:0]   s_rdat;

    logic [1:0]      gnt;
    logic            timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    osiris_wb_arbiter #(
        .AW             (AW),
        .DW             (DW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .m0_cyc_i  (m0_cyc),
        .m0_stb_i  (m0_stb),
        .m0_we_i   (m0_we),
        .m0_sel_i  (m0_sel),
        .m0_adr_i  (m0_adr),
        .m0_dat_i  (m0_wdat),
        .m0_ack_o  (m0_ack),
        .m0_dat_o  (m0_rdat),
        .m1_cyc_i  (m1_cyc),
        .m1_stb_i  (m1_stb),
        .m1_we_i   (m1_we),
        .m1_sel_i  (m1_sel),
        .m1_adr_i  (m1_adr),
        .m1_dat_i  (m1_wdat),
        .m1_ack_o  (m1_ack),
        .m1_dat_o  (m1_rdat),
        .s_cyc_o   (s_cyc),
        .s_stb_o   (s_stb),
        .s_we_o    (s_we),
        .s_sel_o   (s_sel),
        .s_adr_o   (s_adr),
        .s_dat_o   (s_wdat),
        .s_ack_i   (s_ack),
        .s_dat_i   (s_rdat),
        .gnt_o     (gnt),
        .timeout_o (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " gnt"}, 32'(gnt), 32'h0);
        chk({tag, " s_cyc"}, 32'(s_cyc), 32'h0);
        chk({tag, " s_stb"}, 32'(s_stb), 32'h0);
        chk({tag, " s_adr"}, s_adr, 32'h0);
        chk({tag, " m0_ack"}, 32'(m0_ack), 32'h0);
        chk({tag, " m1_ack"}, 32'(m1_ack), 32'h0);
        chk({tag, " timeout"}, 32'(timeout), 32'h0);
    endtask

    initial begin
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = '0; m0_adr = '0; m0_wdat = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = '1; m1_adr = '0; m1_wdat = '0;
        s_ack = 0; s_rdat = '0;

        // Reset state
        #12;
        chk_quiet("reset");
        tick();
        rst = 0;

        // Single M0 read
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_sel = 4'h3; m0_adr = 32'h3000_0004;
        #1;
        chk("rd gnt before edge", 32'(gnt), 32'h0);
        tick();
        chk("rd gnt", 32'(gnt), 32'h1);
        chk("rd s_cyc", 32'(s_cyc), 32'h1);
        chk("rd s_stb", 32'(s_stb), 32'h1);
        chk("rd s_adr", s_adr, 32'h3000_0004);
        chk("rd s_sel", 32'(s_sel), 32'h3);
        chk("rd m0_ack early", 32'(m0_ack), 32'h0);
        s_ack = 1; s_rdat = 32'h1234_5678;
        #1;
        chk("rd m0_ack", 32'(m0_ack), 32'h1);
        chk("rd m0_dat", m0_rdat, 32'h1234_5678);
        chk("rd m1_ack", 32'(m1_ack), 32'h0);
        chk("rd m1_dat", m1_rdat, 32'h0);
        tick();
        m0_cyc = 0; m0_stb = 0; s_ack = 0;
        tick();
        chk("rd release gnt", 32'(gnt), 32'h0);
        s_ack = 1;
        #1;
        chk("ack in idle m0", 32'(m0_ack), 32'h0);
        s_ack = 0;

        // Simultaneous requests out of reset
        rst = 1;
        #1;
        rst = 0;
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0010;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_0020;
        tick();
        chk("tie gnt", 32'(gnt), 32'h1);
        chk("tie s_adr", s_adr, 32'h0000_0010);
        m0_cyc = 0; m0_stb = 0;
        tick();
        chk("tie turnaround", 32'(gnt), 32'h0);
        chk("tie turnaround cyc", 32'(s_cyc), 32'h0);
        tick();
        chk("tie second gnt", 32'(gnt), 32'h2);
        chk("tie second s_adr", s_adr, 32'h0000_0020);
        s_ack = 1; s_rdat = 32'hA5A5_0001;
        #1;
        chk("tie m1_ack", 32'(m1_ack), 32'h1);
        chk("tie m0_ack", 32'(m0_ack), 32'h0);
        chk("tie m0_dat", m0_rdat, 32'h0);
        s_ack = 0;
        m1_cyc = 0; m1_stb = 0;
        tick();

        // Round-robin with both masters requesting continuously
        rst = 1;
        #1;
        rst = 0;
        m0_cyc = 1; m0_stb = 1;
        m1_cyc = 1; m1_stb = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rr gnt %0d", i), 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
            s_ack = 1;
            #1;
            chk($sformatf("rr ack %0d", i), 32'(i % 2 == 0 ? m0_ack : m1_ack), 32'h1);
            tick();
            s_ack = 0;
            if (i % 2 == 0) m0_cyc = 0; else m1_cyc = 0;
            tick();
            chk($sformatf("rr idle %0d", i), 32'(gnt), 32'h0);
            m0_cyc = 1; m1_cyc = 1;
        end

        // Block cycle: M1 holds cyc across strobe gaps while M0 waits
        m0_cyc = 0;
        tick();
        chk("blk gnt", 32'(gnt), 32'h2);
        m0_cyc = 1;
        m1_we = 1;
        for (int j = 0; j < 3; j++) begin
            m1_stb = 1; m1_wdat = 32'hCAFE_0000 + 32'(j); s_ack = 1;
            #1;
            chk($sformatf("blk ack %0d", j), 32'(m1_ack), 32'h1);
            chk($sformatf("blk s_dat %0d", j), s_wdat, 32'hCAFE_0000 + 32'(j));
            chk($sformatf("blk s_we %0d", j), 32'(s_we), 32'h1);
            tick();
            chk($sformatf("blk hold a %0d", j), 32'(gnt), 32'h2);
            m1_stb = 0;
            #1;
            chk($sformatf("blk stb low %0d", j), 32'(s_stb), 32'h0);
            chk($sformatf("blk ack ignored %0d", j), 32'(m1_ack), 32'h0);
            tick();
            chk($sformatf("blk hold b %0d", j), 32'(gnt), 32'h2);
            s_ack = 0;
        end
        m1_cyc = 0; m1_we = 0;
        tick();
        chk("blk release", 32'(gnt), 32'h0);
        tick();
        chk("blk next owner", 32'(gnt), 32'h1);
        m0_cyc = 0; m0_stb = 0;
        tick();

        // Stalled slave
        rst = 1;
        #1;
        rst = 0;
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h3000_0100;
        for (int k = 1; k <= 6; k++) begin
            tick();
`ifdef OSIRIS_WB_TIMEOUT_EN
            if (k == 5) begin
                chk("wd timeout", 32'(timeout), 32'h1);
                chk("wd s_stb", 32'(s_stb), 32'h0);
                chk("wd m0_ack", 32'(m0_ack), 32'h1);
                chk("wd m0_dat", m0_rdat, 32'hDEAD_BEEF);
                chk("wd m1_ack", 32'(m1_ack), 32'h0);
                chk("wd gnt kept", 32'(gnt), 32'h1);
            end else begin
                chk($sformatf("wd quiet %0d", k), 32'(timeout), 32'h0);
                chk($sformatf("wd stb %0d", k), 32'(s_stb), 32'h1);
                chk($sformatf("wd ack %0d", k), 32'(m0_ack), 32'h0);
            end
`else
            chk($sformatf("stall timeout %0d", k), 32'(timeout), 32'h0);
            chk($sformatf("stall stb %0d", k), 32'(s_stb), 32'h1);
            chk($sformatf("stall ack %0d", k), 32'(m0_ack), 32'h0);
            chk($sformatf("stall gnt %0d", k), 32'(gnt), 32'h1);
`endif
        end
        m0_cyc = 0; m0_stb = 0;
        tick();
        chk("stall release", 32'(gnt), 32'h0);

        // Reset during an M1 transfer
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h3000_0200;
        tick();
        chk("mid gnt", 32'(gnt), 32'h2);
        chk("mid s_stb", 32'(s_stb), 32'h1);
        rst = 1;
        s_ack = 1; s_rdat = 32'h5555_AAAA;
        #1;
        chk_quiet("mid reset");
        chk("mid m1_dat", m1_rdat, 32'h0);
        s_ack = 0;
        m0_cyc = 1; m0_stb = 1;
        #2;
        rst = 0;
        tick();
        chk("post reset tie", 32'(gnt), 32'h1);
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
